// File: rtl/navre_io_fifo.sv
// ============================================================================
// navre_io_fifo
//   IO-mapped output capture FIFO: DATA/STATUS/LEVEL/CTRL registers on the
//   navre IO bus, drained by a valid/ready byte stream.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module navre_io_fifo #(
    parameter int BASE_ADDR   = 42,
    parameter int DEPTH_LOG2  = 4,
    parameter bit EOF_ON_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [5:0] io_a,
    input  logic [7:0] io_do,
    output logic [7:0] io_di,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       eof,
    output logic       done
);

    localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [6:0]            c_BASE    = 7'(BASE_ADDR);
    localparam logic [DEPTH_LOG2:0]   c_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_eof;
    logic                  r_ovf;
    logic [7:0]            r_io_di;

    logic [6:0] w_addr7;
    logic [6:0] w_off7;
    logic       w_hit;
    logic [1:0] w_off;
    logic       w_wr_data;
    logic       w_wr_ctrl;
    logic       w_flush;
    logic       w_clear;
    logic       w_zero;
    logic       w_push_req;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_ovf_set;
    logic [8:0] w_count9;
    logic [7:0] w_level;
    logic [7:0] w_status;
    logic [7:0] w_rd_val;

    // Decode in 7 bits so a window near the top of the space never wraps to 0.
    assign w_addr7 = {1'b0, io_a};
    assign w_off7  = w_addr7 - c_BASE;
    assign w_hit   = (w_addr7 >= c_BASE) && (w_off7 < 7'd4);
    assign w_off   = w_off7[1:0];

    assign w_wr_data  = io_we && w_hit && (w_off == 2'd0);
    assign w_wr_ctrl  = io_we && w_hit && (w_off == 2'd3);
    assign w_flush    = w_wr_ctrl && io_do[0];
    assign w_clear    = w_wr_ctrl && io_do[1];
    assign w_zero     = EOF_ON_ZERO && (io_do == 8'h00);
    assign w_push_req = w_wr_data && !w_zero;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = !w_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop;

    assign w_count9 = 9'(r_count);
    assign w_level  = w_count9[8] ? 8'hFF : w_count9[7:0];
    assign w_status = {4'b0000, r_ovf, r_eof, w_full, w_empty};

    always_comb begin
        w_rd_val = 8'h00;
        if (io_re && w_hit) begin
            case (w_off)
                2'd1:    w_rd_val = w_status;
                2'd2:    w_rd_val = w_level;
                default: w_rd_val = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wp] <= io_do;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eof   <= 1'b0;
            r_ovf   <= 1'b0;
            r_io_di <= 8'h00;
        end else begin
            r_io_di <= w_rd_val;
            if (w_clear) begin
                r_eof <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if (w_wr_data && w_zero) begin
                    r_eof <= 1'b1;
                end
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign io_di     = r_io_di;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rp];
    assign eof       = r_eof;
    assign done      = r_eof && w_empty;

endmodule

`default_nettype wire

// File: tb/tb_navre_io_fifo.sv
// ============================================================================
// tb_navre_io_fifo
//   Directed self-checking bench; a second instance with EOF_ON_ZERO=0 shares
//   the input stimulus for the zero-byte comparison.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_navre_io_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       io_re = 1'b0;
    logic       io_we = 1'b0;
    logic [5:0] io_a = 6'd0;
    logic [7:0] io_do = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] io_di, out_data;
    logic       out_valid, eof, done;
    logic [7:0] io_di_b, out_data_b;
    logic       out_valid_b, eof_b, done_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] rv;

    localparam logic [5:0] A_DATA = 6'd42;
    localparam logic [5:0] A_STAT = 6'd43;
    localparam logic [5:0] A_LVL  = 6'd44;
    localparam logic [5:0] A_CTRL = 6'd45;

    navre_io_fifo #(.BASE_ADDR(42), .DEPTH_LOG2(4), .EOF_ON_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_do(io_do), .io_di(io_di), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .eof(eof), .done(done)
    );

    navre_io_fifo #(.BASE_ADDR(42), .DEPTH_LOG2(4), .EOF_ON_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_do(io_do), .io_di(io_di_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .eof(eof_b), .done(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_we = 1'b1; io_a = a; io_do = d;
        cyc();
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] v);
        io_re = 1'b1; io_a = a;
        cyc();
        io_re = 1'b0;
        v = io_di;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
        total++; if ({out_valid, eof, done} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%b exp=000", {out_valid, eof, done}); end
        total++; if (io_di !== 8'h00) begin bad++;
            $display("FAIL reset_io_di got=%h exp=00", io_di); end
        rd(A_STAT, rv);
        total++; if (rv !== 8'h01) begin bad++;
            $display("FAIL reset_status got=%h exp=01", rv); end
        cyc();
        total++; if (io_di !== 8'h00) begin bad++;
            $display("FAIL io_di_idle got=%h exp=00", io_di); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'h00) begin bad++;
            $display("FAIL reset_level got=%h exp=00", rv); end
    endtask

    task automatic test_stream();
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_we = 1'b1; io_a = A_DATA; io_do = seq[i];
            cyc();
            total++; if (out_valid !== 1'b1 || out_data !== seq[i]) begin bad++;
                $display("FAIL stream_byte%0d got=%b/%h exp=1/%h", i, out_valid, out_data, seq[i]); end
        end
        io_we = 1'b0;
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL stream_drained got=%b exp=0", out_valid); end
        out_ready = 1'b0;
        rd(A_LVL, rv);
        total++; if (rv !== 8'h00) begin bad++;
            $display("FAIL stream_level got=%h exp=00", rv); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) wr(A_DATA, 8'(i));
        rd(A_STAT, rv);
        total++; if (rv !== 8'h0A) begin bad++;
            $display("FAIL ovf_status got=%h exp=0a", rv); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'd16) begin bad++;
            $display("FAIL ovf_level got=%h exp=10", rv); end
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin bad++;
                $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i)); end
            cyc();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL ovf_drain_empty got=%b exp=0", out_valid); end
        rd(A_STAT, rv);
        total++; if (rv !== 8'h09) begin bad++;
            $display("FAIL ovf_sticky got=%h exp=09", rv); end
        wr(A_CTRL, 8'h02);
        rd(A_STAT, rv);
        total++; if (rv !== 8'h01) begin bad++;
            $display("FAIL ovf_clear got=%h exp=01", rv); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(A_DATA, 8'hA0 + 8'(i));
        io_we = 1'b1; io_a = A_DATA; io_do = 8'hB0; out_ready = 1'b1;
        cyc();
        io_we = 1'b0; out_ready = 1'b0;
        rd(A_LVL, rv);
        total++; if (rv !== 8'd16) begin bad++;
            $display("FAIL fullpp_level got=%h exp=10", rv); end
        rd(A_STAT, rv);
        total++; if (rv !== 8'h02) begin bad++;
            $display("FAIL fullpp_status got=%h exp=02", rv); end
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            total++; if (out_data !== ((i == 16) ? 8'hB0 : 8'hA0 + 8'(i))) begin bad++;
                $display("FAIL fullpp_drain%0d got=%h exp=%h", i, out_data,
                         (i == 16) ? 8'hB0 : 8'hA0 + 8'(i)); end
            cyc();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL fullpp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_eof();
        out_ready = 1'b0;
        wr(A_DATA, 8'h41);
        wr(A_DATA, 8'h00);
        total++; if (eof !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL eof_flags got=%b%b exp=10", eof, done); end
        total++; if (eof_b !== 1'b0) begin bad++;
            $display("FAIL eof_nz_flag got=%b exp=0", eof_b); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'd1) begin bad++;
            $display("FAIL eof_level got=%h exp=01", rv); end
        total++; if (io_di_b !== 8'd2) begin bad++;
            $display("FAIL eof_nz_level got=%h exp=02", io_di_b); end
        total++; if (out_data !== 8'h41) begin bad++;
            $display("FAIL eof_head got=%h exp=41", out_data); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (done !== 1'b1) begin bad++;
            $display("FAIL eof_done got=%b exp=1", done); end
        wr(A_CTRL, 8'h03);
        total++; if (eof !== 1'b0 || done !== 1'b0 || out_valid_b !== 1'b0) begin bad++;
            $display("FAIL eof_clear got=%b%b%b exp=000", eof, done, out_valid_b); end
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_DATA, 8'h60 + 8'(i));
        rd(A_LVL, rv);
        total++; if (rv !== 8'd5) begin bad++;
            $display("FAIL flush_prelevel got=%h exp=05", rv); end
        out_ready = 1'b1;
        wr(A_CTRL, 8'h01);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL flush_valid got=%b exp=0", out_valid); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'd0) begin bad++;
            $display("FAIL flush_level got=%h exp=00", rv); end
        for (int i = 0; i < 18; i++) wr(A_DATA, 8'h70 + 8'(i));
        wr(A_DATA, 8'h00);
        rd(A_STAT, rv);
        total++; if (rv !== 8'h0E) begin bad++;
            $display("FAIL prerst_status got=%h exp=0e", rv); end
        rst = 1'b1; io_we = 1'b1; io_a = A_DATA; io_do = 8'h99; out_ready = 1'b1;
        cyc();
        rst = 1'b0; io_we = 1'b0; out_ready = 1'b0;
        total++; if ({out_valid, eof, done} !== 3'b000) begin bad++;
            $display("FAIL rst_flags got=%b exp=000", {out_valid, eof, done}); end
        rd(A_STAT, rv);
        total++; if (rv !== 8'h01) begin bad++;
            $display("FAIL rst_status got=%h exp=01", rv); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'h00) begin bad++;
            $display("FAIL rst_level got=%h exp=00", rv); end
        wr(6'd41, 8'h55);
        wr(6'd46, 8'h00);
        wr(A_STAT, 8'h55);
        total++; if (out_valid !== 1'b0 || eof !== 1'b0) begin bad++;
            $display("FAIL offaddr_flags got=%b%b exp=00", out_valid, eof); end
        rd(A_STAT, rv);
        total++; if (rv !== 8'h01) begin bad++;
            $display("FAIL offaddr_status got=%h exp=01", rv); end
        wr(A_DATA, 8'h5A);
        rd(A_DATA, rv);
        total++; if (rv !== 8'h00) begin bad++;
            $display("FAIL data_read got=%h exp=00", rv); end
        rd(6'd41, rv);
        total++; if (rv !== 8'h00) begin bad++;
            $display("FAIL unsel_read got=%h exp=00", rv); end
        rd(A_LVL, rv);
        total++; if (rv !== 8'h01) begin bad++;
            $display("FAIL final_level got=%h exp=01", rv); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_eof();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
